// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    FLUSH,
    HALT
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIR
  } pc_sel_e;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NULL_OP  = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with hold / increment / redirect next-value mux
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     sel,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [29:0] next_word
);

  logic [31:0] pc_mux;
  logic [31:0] pc_next;

  always_comb begin
    pc_mux = pc;
    unique case (sel)
      PC_INC:   pc_mux = pc + 32'd4;
      PC_REDIR: pc_mux = target;
      default:  pc_mux = pc;
    endcase
    // Word alignment is enforced here so no path can load a misaligned PC.
    pc_next = pc_mux & ~32'h0000_0003;
  end

  assign next_word = pc_next[31:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= BOOT_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch FSM, instruction hold register, halt capture and accept counter
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] halt_pc,
  output logic [31:0] fetch_count
);

  fetch_state_e state, state_nxt;
  pc_sel_e      pc_sel;
  logic [31:0]  pc;
  logic [29:0]  next_word;
  logic         load_inst;
  logic         clr_valid;
  logic         set_halt;
  logic         count_inc;

  fetch_pc_reg #(.BOOT_PC(BOOT_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (pc_sel),
    .target    (redirect_pc),
    .pc        (pc),
    .next_word (next_word)
  );

  always_comb begin
    state_nxt = state;
    pc_sel    = PC_HOLD;
    load_inst = 1'b0;
    clr_valid = 1'b0;
    set_halt  = 1'b0;
    count_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_valid) pc_sel = PC_REDIR;
        state_nxt = FETCH;
      end
      FETCH: begin
        // A pending request cannot be withdrawn, so a redirect without ack must drain it in FLUSH.
        if (redirect_valid) begin
          pc_sel    = PC_REDIR;
          state_nxt = mem_ack ? FETCH : FLUSH;
        end else if (mem_ack) begin
          if (mem_rdata == NULL_OP) begin
            set_halt  = 1'b1;
            state_nxt = HALT;
          end else begin
            load_inst = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_sel    = PC_REDIR;
          clr_valid = 1'b1;
          state_nxt = FETCH;
        end else if (inst_valid && inst_ready) begin
          pc_sel    = PC_INC;
          clr_valid = 1'b1;
          count_inc = 1'b1;
          state_nxt = FETCH;
        end
      end
      FLUSH: begin
        if (redirect_valid) pc_sel = PC_REDIR;
        if (mem_ack) state_nxt = FETCH;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= BOOT_PC[31:2];
      inst_valid  <= 1'b0;
      inst        <= 32'h0;
      inst_pc     <= 32'h0;
      halted      <= 1'b0;
      halt_pc     <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == FETCH) || (state_nxt == FLUSH);
      // The address only advances when a fresh request starts; FLUSH keeps the old one.
      if (state_nxt == FETCH) mem_addr <= next_word;
      if (load_inst) begin
        inst       <= mem_rdata;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end else if (clr_valid) begin
        inst_valid <= 1'b0;
      end
      if (set_halt) begin
        halted  <= 1'b1;
        halt_pc <= pc;
      end
      if (count_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed table-driven bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] halt_pc;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .halt_pc        (halt_pc),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [29:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic [31:0] e_cnt;
    logic        e_halt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic ack, logic [31:0] rdata, logic ready, logic rv,
                              logic [31:0] rpc, logic e_req, logic [29:0] e_addr,
                              logic e_iv, logic [31:0] e_inst, logic [31:0] e_ipc,
                              logic [31:0] e_cnt, logic e_halt);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
    v.e_ipc = e_ipc; v.e_cnt = e_cnt; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mem_ack        = 1'b0;
    mem_rdata      = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // Leaves the bench at a negedge with reset just released and the DUT in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 30'h0,        0, 32'h0,         32'h0,         0, 0);
    vecs[1]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 30'h0010_0000, 0, 32'h0,        32'h0,         0, 0);
    vecs[2]  = mk(1, 32'h2008_0001, 1, 0, 32'h0,         1, 30'h0010_0000, 0, 32'h0,        32'h0,         0, 0);
    vecs[3]  = mk(0, 32'h0,         1, 0, 32'h0,         0, 30'h0,        1, 32'h2008_0001, 32'h0040_0000, 0, 0);
    vecs[4]  = mk(1, 32'h1111_0002, 0, 0, 32'h0,         1, 30'h0010_0001, 0, 32'h0,        32'h0,         1, 0);
    for (int i = 5; i <= 9; i++)
      vecs[i] = mk(0, 32'h0,        0, 0, 32'h0,         0, 30'h0,        1, 32'h1111_0002, 32'h0040_0004, 1, 0);
    vecs[10] = mk(0, 32'h0,         1, 0, 32'h0,         0, 30'h0,        1, 32'h1111_0002, 32'h0040_0004, 1, 0);
    vecs[11] = mk(0, 32'h0,         0, 1, 32'h0040_0103, 1, 30'h0010_0002, 0, 32'h0,        32'h0,         2, 0);
    vecs[12] = mk(0, 32'h0,         0, 0, 32'h0,         1, 30'h0010_0002, 0, 32'h0,        32'h0,         2, 0);
    vecs[13] = mk(0, 32'h0,         0, 0, 32'h0,         1, 30'h0010_0002, 0, 32'h0,        32'h0,         2, 0);
    vecs[14] = mk(1, 32'h0,         0, 0, 32'h0,         1, 30'h0010_0002, 0, 32'h0,        32'h0,         2, 0);
    vecs[15] = mk(1, 32'h2222_0003, 0, 0, 32'h0,         1, 30'h0010_0040, 0, 32'h0,        32'h0,         2, 0);
    vecs[16] = mk(0, 32'h0,         1, 1, 32'h0000_0200, 0, 30'h0,        1, 32'h2222_0003, 32'h0040_0100, 2, 0);
    vecs[17] = mk(1, 32'h0,         0, 1, 32'h0000_0302, 1, 30'h0000_0080, 0, 32'h0,        32'h0,         2, 0);
    vecs[18] = mk(1, 32'h3333_0004, 0, 0, 32'h0,         1, 30'h0000_00C0, 0, 32'h0,        32'h0,         2, 0);
    vecs[19] = mk(0, 32'h0,         1, 0, 32'h0,         0, 30'h0,        1, 32'h3333_0004, 32'h0000_0300, 2, 0);
    vecs[20] = mk(0, 32'h0,         0, 0, 32'h0,         1, 30'h0000_00C1, 0, 32'h0,        32'h0,         3, 0);

    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_halt_pc", halt_pc, 0);
    chk("rst_fetch_count", fetch_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (i > 0) step();
      chk($sformatf("v%0d_req", i), mem_req, vecs[i].e_req);
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_iv", i), inst_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
        chk($sformatf("v%0d_ipc", i), inst_pc, vecs[i].e_ipc);
      end
      chk($sformatf("v%0d_cnt", i), fetch_count, vecs[i].e_cnt);
      chk($sformatf("v%0d_halt", i), halted, vecs[i].e_halt);
      mem_ack        = vecs[i].ack;
      mem_rdata      = vecs[i].rdata;
      inst_ready     = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
    end

    // Null op on the third word.
    do_reset();
    inst_ready = 1'b1;
    step(); mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    step(); mem_ack = 1'b0;
    step(); mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
    step(); mem_ack = 1'b0;
    step();
    chk("halt_seq_addr", mem_addr, 30'h0010_0002);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    mem_ack = 1'b0;
    chk("halted", halted, 1);
    chk("halt_pc", halt_pc, 32'h0040_0008);
    chk("halt_req", mem_req, 0);
    chk("halt_iv", inst_valid, 0);
    chk("halt_cnt", fetch_count, 2);
    for (int k = 0; k < 3; k++) begin
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
      mem_ack = 1'b1; mem_rdata = 32'h0000_0005;
      step();
      chk($sformatf("halt_stay_req%0d", k), mem_req, 0);
      chk($sformatf("halt_stay_h%0d", k), halted, 1);
      chk($sformatf("halt_stay_iv%0d", k), inst_valid, 0);
      chk($sformatf("halt_stay_pc%0d", k), halt_pc, 32'h0040_0008);
    end

    // Redirect from IDLE to the top word and PC wrap on accept.
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("wrap_req", mem_req, 1);
    chk("wrap_addr", mem_addr, 30'h3FFF_FFFF);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0033;
    step();
    mem_ack = 1'b0;
    chk("wrap_iv", inst_valid, 1);
    chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_req", mem_req, 1);
    chk("wrap_next_addr", mem_addr, 30'h0);
    chk("wrap_cnt", fetch_count, 1);

    // Asynchronous reset while a request is outstanding.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_cnt", fetch_count, 0);
    chk("async_rst_iv", inst_valid, 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    chk("restart_idle_req", mem_req, 0);
    step();
    chk("restart_req", mem_req, 1);
    chk("restart_addr", mem_addr, 30'h0010_0000);
    chk("restart_cnt", fetch_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
